// File: rtl/sigmoid_pkg.sv
// Shared constants for the interpolated sigmoid: the default 16-entry table for
// the 8-bit geometry and a generic signed saturation helper.
package sigmoid_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    // Indexed by the two's-complement segment number: 0..7 positive, 8..15 negative.
    localparam logic signed [7:0] SIGMOID_LUT16_W8 [16] = '{
        8'sd8,  8'sd11, 8'sd14, 8'sd15, 8'sd15, 8'sd15, 8'sd15, 8'sd15,
        8'sd0,  8'sd0,  8'sd0,  8'sd0,  8'sd0,  8'sd0,  8'sd1,  8'sd4
    };

    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                      input int unsigned     w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/sigmoid_lut_ram.sv
// Sigmoid table register file: one write port and two combinational reads
// returning the segment base and its right-hand neighbour.
module sigmoid_lut_ram
    import sigmoid_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic signed [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    output logic signed [DATA_W-1:0] base_o,
    output logic signed [DATA_W-1:0] nxt_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] MAX_POS = ADDR_W'((1 << (ADDR_W - 1)) - 1);

    typedef logic signed [DATA_W-1:0] table_t [DEPTH];

    function automatic table_t init_table();
        table_t t;
        for (int i = 0; i < DEPTH; i++) begin
            if (DATA_W == DEF_DATA_W && ADDR_W == DEF_ADDR_W)
                t[i] = DATA_W'(SIGMOID_LUT16_W8[4'(i)]);
            else
                t[i] = '0;
        end
        return t;
    endfunction

    // Contents live outside the reset domain so rst never disturbs the table.
    table_t mem_q = init_table();

    logic [ADDR_W-1:0] nxt_idx;

    always_ff @(posedge clk) begin
        if (wr_en_i)
            mem_q[wr_addr_i] <= wr_data_i;
    end

    // Segment -1 interpolates toward segment 0; the top positive segment saturates flat.
    always_comb begin
        nxt_idx = rd_addr_i + ADDR_W'(1);
        if (rd_addr_i == '1)
            nxt_idx = '0;
        else if (rd_addr_i == MAX_POS)
            nxt_idx = rd_addr_i;
    end

    assign base_o = mem_q[rd_addr_i];
    assign nxt_o  = mem_q[nxt_idx];

endmodule

// File: rtl/sigmoid_interp_lut.sv
// Piecewise-linear sigmoid: LUT lookup, slope multiply, add and saturate
// through a three-stage pipeline with ready/valid flow control.
module sigmoid_interp_lut
    import sigmoid_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data
);

    localparam int FRAC_W = DATA_W - ADDR_W;
    localparam int PROD_W = DATA_W + FRAC_W + 1;
    localparam int SUM_W  = DATA_W + 2;

    logic                     adv;
    logic [ADDR_W-1:0]        addr;
    logic [FRAC_W-1:0]        frac;
    logic signed [DATA_W-1:0] base;
    logic signed [DATA_W-1:0] nxt;

    logic                     vld_p1_q;
    logic signed [DATA_W-1:0] base_p1_q;
    logic signed [DATA_W-1:0] nxt_p1_q;
    logic [FRAC_W-1:0]        frac_p1_q;

    logic signed [DATA_W:0]   diff_p1;
    logic signed [PROD_W-1:0] prod_p2_d;
    logic                     vld_p2_q;
    logic signed [DATA_W-1:0] base_p2_q;
    logic signed [PROD_W-1:0] prod_p2_q;

    logic signed [SUM_W-1:0]  sum_p2;
    logic signed [DATA_W-1:0] y_d;
    logic                     vld_p3_q;
    logic signed [DATA_W-1:0] y_q;

    // The whole pipe moves as one unit; only a held output blocks it.
    assign adv      = !vld_p3_q || out_ready;
    assign in_ready = adv;

    assign addr = x[DATA_W-1 -: ADDR_W];
    assign frac = x[FRAC_W-1:0];

    sigmoid_lut_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lut (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (addr),
        .base_o    (base),
        .nxt_o     (nxt)
    );

    // Stage 1: capture segment endpoints and fraction
    always_ff @(posedge clk) begin
        if (rst)
            vld_p1_q <= 1'b0;
        else if (adv)
            vld_p1_q <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            base_p1_q <= base;
            nxt_p1_q  <= nxt;
            frac_p1_q <= frac;
        end
    end

    // Stage 2: slope times fraction
    assign diff_p1   = (DATA_W + 1)'(nxt_p1_q) - (DATA_W + 1)'(base_p1_q);
    assign prod_p2_d = PROD_W'(diff_p1) * $signed({{(PROD_W - FRAC_W){1'b0}}, frac_p1_q});

    always_ff @(posedge clk) begin
        if (rst)
            vld_p2_q <= 1'b0;
        else if (adv)
            vld_p2_q <= vld_p1_q;
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            base_p2_q <= base_p1_q;
            prod_p2_q <= prod_p2_d;
        end
    end

    // Stage 3: add the floored increment and saturate
    assign sum_p2 = SUM_W'(base_p2_q) + SUM_W'(prod_p2_q >>> FRAC_W);
    assign y_d    = DATA_W'(sat_signed(32'(sum_p2), DATA_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p3_q <= 1'b0;
            y_q      <= '0;
        end else if (adv) begin
            vld_p3_q <= vld_p2_q;
            y_q      <= y_d;
        end
    end

    assign out_valid = vld_p3_q;
    assign y         = y_q;

endmodule

// File: doc/sigmoid_interp_lut.md
SIGMOID_INTERP_LUT -- requirements
Module: sigmoid_interp_lut

Interface
REQ-001 SHALL have parameter DATA_W, default 8, signed width of input x and output y (min 4).
REQ-002 SHALL have parameter ADDR_W, default 4, LUT index width; LUT depth = 2**ADDR_W; FRAC_W = DATA_W-ADDR_W SHALL be >= 1.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  x presented.
REQ-006 in_ready  output  1  x accepted when in_valid && in_ready.
REQ-007 x  input  DATA_W  signed activation argument.
REQ-008 out_valid  output  1  y valid.
REQ-009 out_ready  input  1  downstream accepts y when out_valid && out_ready.
REQ-010 y  output  DATA_W  signed interpolated activation.
REQ-011 wr_en  input  1  LUT entry write strobe.
REQ-012 wr_addr  input  ADDR_W  LUT entry index.
REQ-013 wr_data  input  DATA_W  signed LUT entry value.

Function
REQ-014 Index addr = x[DATA_W-1 -: ADDR_W] (two's-complement segment; 0..2**(ADDR_W-1)-1 positive, upper half negative); frac = x[FRAC_W-1:0], unsigned.
REQ-015 base = lut[addr]; nxt = lut[0] when addr = all-ones (-1 segment wraps to zero segment); nxt = lut[addr] when addr = 2**(ADDR_W-1)-1 (max positive, hold); else nxt = lut[addr+1] (mod depth).
REQ-016 y = sat_DATA_W(base + ((nxt-base)*frac >>> FRAC_W)); difference DATA_W+1 bits signed, product DATA_W+FRAC_W+1 bits, arithmetic shift, saturate to signed DATA_W range.
REQ-017 Pipeline 3 stages: S1 capture base/nxt/frac, S2 multiply, S3 add+saturate into y register; latency 3 cycles from acceptance to out_valid with no stall.
REQ-018 Pipeline advance adv = !out_valid || out_ready; in_ready = adv; all stages shift only on adv; bubbles propagate as valid=0.
REQ-019 Throughput 1 sample/cycle when out_ready held high; y and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 LUT read for a sample occurs in its acceptance cycle; wr_en in the same cycle updates the entry at the clock edge, the accepted sample uses the old value, later samples the new.
REQ-021 Writes accepted every cycle regardless of handshake state; no ordering constraint besides REQ-020.

Reset
REQ-022 rst SHALL clear all stage valid bits: out_valid = 0, y = 0 on the cycle after rst high; in_ready = 1 while out_valid = 0.
REQ-023 rst mid-operation SHALL discard all in-flight samples; no output for them after reset.
REQ-024 rst SHALL NOT alter LUT contents; power-up LUT = package default table.

Structure
REQ-025 Shared package sigmoid_pkg SHALL hold default table SIGMOID_LUT16_W8 = {8,11,14,15,15,15,15,15,0,0,0,0,0,0,1,4} (index 0..15) and saturation helper; non-default geometries power up zeroed.
REQ-026 One sub-module sigmoid_lut_ram: depth 2**ADDR_W x DATA_W register file, one write port, two combinational read ports (base, nxt) including REQ-015 next-index logic.

Verification (DATA_W=8, ADDR_W=4, default table)
REQ-027 x=0x00, out_ready=1 -> y=8 exactly 3 cycles after acceptance; x=0x08 -> y=9.
REQ-028 x=0xF8 (wrap) -> y=6; x=0x7F (hold) -> y=15; x=0x88 -> y=0.
REQ-029 Back-to-back 0x00,0x08,0xF8 with out_ready=0 for 5 cycles -> in_ready low after 3 accepted, y=8 held; release -> 8,9,6 in order, no loss/duplication.
REQ-030 wr_en addr1=20 then x=0x08 -> y=14; write same cycle as accepting x=0x08 -> y=9.
REQ-031 rst asserted with 2 samples in flight -> out_valid=0 next cycle, neither sample emitted; LUT write from REQ-030 persists.
REQ-032 wr_en addr0=127, addr1=-128, x=0x0F -> saturated y within [-128,127], matches REQ-016 model (y=-113).
